// File: rtl/syla55_256x8x12_cm2.sv
// 256 x 96-bit single-port SRAM model with 12 byte-lane write enables,
// registered read data and a one-cycle read-valid strobe.
module syla55_256x8x12_cm2 #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 12,
    parameter int LANE_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [ADDR_W-1:0]        A,
    input  logic [LANES*LANE_W-1:0]  DI,
    input  logic [LANES-1:0]         WEB,
    input  logic                     CSB,
    input  logic                     DVSE,
    input  logic [3:0]               DVS,
    output logic [LANES*LANE_W-1:0]  DO,
    output logic                     RD_VALID
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORD_W = LANES * LANE_W;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              rd_en;
    logic              wr_en;
    logic [WORD_W-1:0] do_d;
    logic [WORD_W-1:0] do_q;
    logic              rd_valid_d;
    logic              rd_valid_q;
    logic              unused_margin;

    // Margin-control pins are accepted for pin compatibility only.
    assign unused_margin = ^{DVSE, DVS};

    assign rd_en = !CSB && (&WEB);
    assign wr_en = !CSB && !(&WEB);

    // The array has no reset so its contents survive RESET_N; writes are
    // blocked while reset is held.
    always_ff @(posedge CLK) begin
        if (RESET_N && wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (!WEB[k]) begin
                    mem[A][k*LANE_W +: LANE_W] <= DI[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        do_d       = do_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            do_d = mem[A];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            do_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            do_q       <= do_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign DO       = do_q;
    assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_syla55_256x8x12_cm2.sv
// Directed, table-driven bench for syla55_256x8x12_cm2 with hand-written
// sequences for asynchronous reset behaviour.
module tb_syla55_256x8x12_cm2;

    logic        clk;
    logic        reset_n;
    logic [7:0]  a;
    logic [95:0] di;
    logic [11:0] web;
    logic        csb;
    logic        dvse;
    logic [3:0]  dvs;
    logic [95:0] dout;
    logic        rd_valid;

    int n_pass;
    int n_total;

    typedef struct {
        string       name;
        logic        csb;
        logic [11:0] web;
        logic [7:0]  a;
        logic [95:0] di;
        logic        dvse;
        logic [3:0]  dvs;
        logic [95:0] exp_do;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    localparam logic [95:0] D1   = 96'h0102030405060708090A0B0C;
    localparam logic [95:0] ALLF = {12{8'hFF}};
    localparam logic [95:0] F00  = {{11{8'hFF}}, 8'h00};
    localparam logic [95:0] W11  = {12{8'h11}};
    localparam logic [95:0] W22  = {12{8'h22}};
    localparam logic [95:0] W33  = {12{8'h33}};
    localparam logic [95:0] WAA  = {12{8'hAA}};
    localparam logic [95:0] M5   = 96'h0102030405060708AAAAAAAA;

    syla55_256x8x12_cm2 dut (
        .CLK      (clk),
        .RESET_N  (reset_n),
        .A        (a),
        .DI       (di),
        .WEB      (web),
        .CSB      (csb),
        .DVSE     (dvse),
        .DVS      (dvs),
        .DO       (dout),
        .RD_VALID (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(string name, logic c, logic [11:0] w, logic [7:0] ad,
                                logic [95:0] d, logic ve, logic [3:0] vs,
                                logic [95:0] ed, logic ev);
        vec_t v;
        v.name = name; v.csb = c; v.web = w; v.a = ad; v.di = d;
        v.dvse = ve; v.dvs = vs; v.exp_do = ed; v.exp_valid = ev;
        vecs.push_back(v);
    endfunction

    task automatic check_output(string name, logic [95:0] exp_do, logic exp_valid);
        n_total++;
        if (dout === exp_do && rd_valid === exp_valid) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: DO=%h RD_VALID=%b, expected DO=%h RD_VALID=%b",
                     name, dout, rd_valid, exp_do, exp_valid);
        end
    endtask

    task automatic drive(logic c, logic [11:0] w, logic [7:0] ad, logic [95:0] d,
                         logic ve, logic [3:0] vs);
        csb = c; web = w; a = ad; di = d; dvse = ve; dvs = vs;
    endtask

    task automatic apply_stimulus(vec_t v);
        @(negedge clk);
        drive(v.csb, v.web, v.a, v.di, v.dvse, v.dvs);
        @(posedge clk);
        #1;
        check_output(v.name, v.exp_do, v.exp_valid);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        drive(1'b1, 12'hFFF, 8'h00, '0, 1'b0, 4'h0);

        add("wr5_full",   0, 12'h000, 8'h05, D1,   0, 4'h0, '0,  0);
        add("wr0_ff",     0, 12'h000, 8'h00, ALLF, 0, 4'h0, '0,  0);
        add("wr0_lane0",  0, 12'hFFE, 8'h00, '0,   0, 4'h0, '0,  0);
        add("wr1",        0, 12'h000, 8'h01, W11,  0, 4'h0, '0,  0);
        add("wr2",        0, 12'h000, 8'h02, W22,  0, 4'h0, '0,  0);
        add("wr3",        0, 12'h000, 8'h03, W33,  0, 4'h0, '0,  0);
        add("rd5",        0, 12'hFFF, 8'h05, '0,   0, 4'h0, D1,  1);
        add("idle1",      1, 12'hFFF, 8'h00, '0,   0, 4'h0, D1,  0);
        add("idle2",      1, 12'h000, 8'h01, WAA,  0, 4'h0, D1,  0);
        add("idle3",      1, 12'hFFF, 8'h02, '0,   0, 4'h0, D1,  0);
        add("stream0",    0, 12'hFFF, 8'h00, '0,   0, 4'h0, F00, 1);
        add("stream1",    0, 12'hFFF, 8'h01, '0,   0, 4'h0, W11, 1);
        add("stream2",    0, 12'hFFF, 8'h02, '0,   0, 4'h0, W22, 1);
        add("stream3",    0, 12'hFFF, 8'h03, '0,   0, 4'h0, W33, 1);
        add("wr5_part",   0, 12'hFF0, 8'h05, WAA,  0, 4'h0, W33, 0);
        add("rd5_merge",  0, 12'hFFF, 8'h05, '0,   0, 4'h0, M5,  1);
        add("wr6_margin", 0, 12'h000, 8'h06, D1,   1, 4'hF, M5,  0);
        add("rd6_margin", 0, 12'hFFF, 8'h06, '0,   1, 4'hF, D1,  1);

        #12;
        check_output("reset_state", '0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Asynchronous reset between edges clears outputs at once.
        @(negedge clk);
        drive(1'b0, 12'hFFF, 8'h06, '0, 1'b0, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_rst_immediate", '0, 1'b0);
        @(posedge clk);
        #1;
        check_output("rd_aborted_in_reset", '0, 1'b0);

        @(negedge clk);
        drive(1'b0, 12'h000, 8'h05, '0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        check_output("wr_blocked_in_reset", '0, 1'b0);

        @(negedge clk);
        drive(1'b1, 12'hFFF, 8'h00, '0, 1'b0, 4'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle_after_release", '0, 1'b0);

        @(negedge clk);
        drive(1'b0, 12'hFFF, 8'h05, '0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        check_output("rd5_after_reset", M5, 1'b1);

        @(negedge clk);
        drive(1'b1, 12'hFFF, 8'h00, '0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        check_output("hold_after_reset", M5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
